// File: rtl/systolic_block_port.sv
// Multi-lane serial block port: per-lane block capture, register-access packet decode,
// shared register bank exported in parallel, one-block-delayed serial output.
module systolic_block_port #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned BLOCK_LEN = 16,
  parameter int unsigned NCH       = 2,
  parameter int unsigned DEPTH     = 4,
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  localparam int unsigned BW = $clog2(BLOCK_LEN),
  localparam int unsigned RW = BLOCK_LEN * DATA_W,
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NCH*DATA_W-1:0] lane_in,
  input  logic [NCH-1:0]        lane_ctrl_in,
  output logic [NCH*DATA_W-1:0] lane_out,
  output logic [NCH-1:0]        lane_ctrl_out,
  output logic [BW-1:0]         beat,
  output logic                  blk_start,
  output logic [DEPTH*RW-1:0]   regs_flat,
  output logic [DEPTH-1:0]      wr_strobe
);

  if (BLOCK_LEN < 16) begin : g_len_chk
    $error("BLOCK_LEN must be at least 16");
  end
  if (int'(BASE_ADDR) + DEPTH > 256) begin : g_addr_chk
    $error("BASE_ADDR + DEPTH exceeds the 8-bit address space");
  end

  logic [BW-1:0]        beat_q;
  logic [DATA_W-1:0]    in_buf_q  [NCH][BLOCK_LEN];
  logic [BLOCK_LEN-1:0] in_ctrl_q [NCH];
  logic [DATA_W-1:0]    out_buf_q [NCH][BLOCK_LEN];
  logic [BLOCK_LEN-1:0] out_ctrl_q [NCH];
  logic [RW-1:0]        bank_q [DEPTH];

  logic [DATA_W-1:0]    blk_data [NCH][BLOCK_LEN];
  logic [BLOCK_LEN-1:0] blk_ctrl [NCH];
  logic [DATA_W-1:0]    nxt_buf  [NCH][BLOCK_LEN];
  logic [BLOCK_LEN-1:0] nxt_ctrl [NCH];
  logic [RW-1:0]        bank_d   [DEPTH];
  logic [DEPTH-1:0]     strobe_d;
  logic                 boundary;

  assign boundary  = (beat_q == BW'(BLOCK_LEN - 1));
  assign beat      = beat_q;
  assign blk_start = (beat_q == '0);

  for (genvar r = 0; r < DEPTH; r++) begin : g_flat
    assign regs_flat[r*RW +: RW] = bank_q[r];
  end

  // Whole-block decode; the final beat comes straight from the live inputs.
  always_comb begin
    strobe_d = '0;
    for (int r = 0; r < DEPTH; r++) bank_d[r] = bank_q[r];
    for (int j = 0; j < NCH; j++) begin
      logic [7:0]    addr;
      logic          hit;
      logic [IW-1:0] idx;
      logic [RW-1:0] payload;
      for (int k = 0; k < BLOCK_LEN; k++) blk_data[j][k] = in_buf_q[j][k];
      blk_ctrl[j] = in_ctrl_q[j];
      blk_data[j][BLOCK_LEN-1] = lane_in[j*DATA_W +: DATA_W];
      blk_ctrl[j][BLOCK_LEN-1] = lane_ctrl_in[j];
      for (int b = 0; b < 8; b++) addr[7-b] = blk_ctrl[j][8+b];
      hit = blk_ctrl[j][0] && (addr >= BASE_ADDR) &&
            ({1'b0, addr} < ({1'b0, BASE_ADDR} + 9'(DEPTH)));
      idx = IW'(addr - BASE_ADDR);
      for (int k = 0; k < BLOCK_LEN; k++) begin
        payload[(BLOCK_LEN-k)*DATA_W-1 -: DATA_W] = blk_data[j][k];
        nxt_buf[j][k] = blk_data[j][k];
      end
      nxt_ctrl[j] = blk_ctrl[j];
      if (hit && blk_ctrl[j][1]) begin
        // Lanes are walked in ascending order so the highest lane wins a collision.
        bank_d[idx]   = blk_ctrl[j][3] ? (bank_q[idx] ^ payload) : payload;
        strobe_d[idx] = 1'b1;
        for (int k = 0; k < BLOCK_LEN; k++) nxt_buf[j][k] = '0;
        nxt_ctrl[j] = '0;
      end else if (hit && blk_ctrl[j][2]) begin
        for (int k = 0; k < BLOCK_LEN; k++) begin
          nxt_buf[j][k] = bank_q[idx][(BLOCK_LEN-k)*DATA_W-1 -: DATA_W];
        end
        nxt_ctrl[j][2] = 1'b0;
        nxt_ctrl[j][4] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q        <= '0;
      lane_out      <= '0;
      lane_ctrl_out <= '0;
      wr_strobe     <= '0;
      for (int r = 0; r < DEPTH; r++) bank_q[r] <= '0;
      for (int j = 0; j < NCH; j++) begin
        in_ctrl_q[j]  <= '0;
        out_ctrl_q[j] <= '0;
        for (int k = 0; k < BLOCK_LEN; k++) begin
          in_buf_q[j][k]  <= '0;
          out_buf_q[j][k] <= '0;
        end
      end
    end else begin
      beat_q    <= boundary ? '0 : beat_q + 1'b1;
      wr_strobe <= boundary ? strobe_d : '0;
      for (int j = 0; j < NCH; j++) begin
        in_buf_q[j][beat_q]           <= lane_in[j*DATA_W +: DATA_W];
        in_ctrl_q[j][beat_q]          <= lane_ctrl_in[j];
        lane_out[j*DATA_W +: DATA_W]  <= out_buf_q[j][beat_q];
        lane_ctrl_out[j]              <= out_ctrl_q[j][beat_q];
      end
      if (boundary) begin
        for (int r = 0; r < DEPTH; r++) bank_q[r] <= bank_d[r];
        for (int j = 0; j < NCH; j++) begin
          out_ctrl_q[j] <= nxt_ctrl[j];
          for (int k = 0; k < BLOCK_LEN; k++) out_buf_q[j][k] <= nxt_buf[j][k];
        end
      end
    end
  end

endmodule
